// File: rtl/octree_bfs_ctrl.sv
// Top-level sequencer for the octree BFS AXI datapath: walks the interface block through
// READING/UPDATING/WORK per 32-point batch, then WRITING, with a progress watchdog.
module octree_bfs_ctrl #(
    parameter int unsigned POINTS_PER_BATCH = 32,
    parameter int unsigned WDOG_CYCLES      = 65535,
    parameter int unsigned WCNT_WIDTH       = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [31:0]           i_total_points,
    input  logic                  i_read_TxnDone,
    input  logic                  i_write_TxnDone,
    input  logic                  i_initwritetxn,
    input  logic                  i_work_done,
    input  logic                  i_bfs_finish,
    output logic [2:0]            o_state,
    output logic                  o_build_start,
    output logic                  o_bfs_start,
    output logic [5:0]            o_batch_valid,
    output logic [31:0]           o_points_done,
    output logic [WCNT_WIDTH-1:0] o_wr_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    localparam int unsigned WdogWidth = $clog2(WDOG_CYCLES + 1);
    localparam logic [WdogWidth-1:0] WdogLast = WdogWidth'(WDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StReading  = 3'd1,
        StUpdating = 3'd2,
        StWork     = 3'd3,
        StWriting  = 3'd4,
        StDone     = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [31:0]           total_q, total_d;
    logic [31:0]           points_done_q, points_done_d;
    logic [5:0]            batch_valid_q, batch_valid_d;
    logic [WCNT_WIDTH-1:0] wr_count_q, wr_count_d;
    logic [WCNT_WIDTH-1:0] outstanding_q, outstanding_d;
    logic                  finish_q, finish_d;
    logic [WdogWidth-1:0]  wdog_q, wdog_d;
    logic                  error_q, error_d;
    logic                  build_start_q, build_start_d;
    logic                  bfs_start_q, bfs_start_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic        progress;
    logic        wdog_active;
    logic        wr_dec;
    logic [31:0] remaining;
    logic [32:0] points_sum;

    always_comb begin
        state_d       = state_q;
        total_d       = total_q;
        points_done_d = points_done_q;
        batch_valid_d = batch_valid_q;
        wr_count_d    = wr_count_q;
        outstanding_d = outstanding_q;
        finish_d      = finish_q;
        error_d       = error_q;
        build_start_d = 1'b0;
        bfs_start_d   = 1'b0;
        done_d        = 1'b0;

        progress    = i_read_TxnDone | i_write_TxnDone | i_initwritetxn | i_work_done;
        wdog_active = (state_q == StReading) || (state_q == StWork) || (state_q == StWriting);
        wr_dec      = i_write_TxnDone && (outstanding_q != '0);
        remaining   = total_q - points_done_q;
        points_sum  = {1'b0, points_done_q} + 33'(batch_valid_q);

        unique case (state_q)
            StIdle: begin
                if (i_start && (i_total_points != 32'd0)) begin
                    state_d       = StReading;
                    total_d       = i_total_points;
                    points_done_d = '0;
                    wr_count_d    = '0;
                    outstanding_d = '0;
                    finish_d      = 1'b0;
                    error_d       = 1'b0;
                end
            end
            StReading: begin
                if (i_read_TxnDone) begin
                    state_d = StUpdating;
                    if (remaining >= 32'(POINTS_PER_BATCH)) begin
                        batch_valid_d = 6'(POINTS_PER_BATCH);
                    end else begin
                        batch_valid_d = remaining[5:0];
                    end
                end
            end
            StUpdating: begin
                state_d       = StWork;
                build_start_d = 1'b1;
                points_done_d = (points_sum > {1'b0, total_q}) ? total_q : points_sum[31:0];
            end
            StWork: begin
                if (i_work_done) begin
                    if (points_done_q < total_q) begin
                        state_d = StReading;
                    end else begin
                        state_d     = StWriting;
                        bfs_start_d = 1'b1;
                    end
                end
            end
            StWriting: begin
                if (i_initwritetxn && !wr_dec) begin
                    outstanding_d = outstanding_q + WCNT_WIDTH'(1);
                end else if (!i_initwritetxn && wr_dec) begin
                    outstanding_d = outstanding_q - WCNT_WIDTH'(1);
                end
                if (wr_dec) begin
                    wr_count_d = wr_count_q + WCNT_WIDTH'(1);
                end
                if (i_bfs_finish) begin
                    finish_d = 1'b1;
                end
                if (finish_q && (outstanding_q == '0) && !i_initwritetxn) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (wdog_active && !progress && (wdog_q == WdogLast)) begin
            state_d       = StIdle;
            error_d       = 1'b1;
            build_start_d = 1'b0;
            bfs_start_d   = 1'b0;
            done_d        = 1'b0;
        end

        // Abort freezes every counter and the error flag, only the state moves.
        if (i_abort && (state_q != StIdle)) begin
            state_d       = StIdle;
            total_d       = total_q;
            points_done_d = points_done_q;
            batch_valid_d = batch_valid_q;
            wr_count_d    = wr_count_q;
            outstanding_d = outstanding_q;
            finish_d      = finish_q;
            error_d       = error_q;
            build_start_d = 1'b0;
            bfs_start_d   = 1'b0;
            done_d        = 1'b0;
        end

        if ((state_d != state_q) || progress || !wdog_active) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + WdogWidth'(1);
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q       <= StIdle;
            total_q       <= '0;
            points_done_q <= '0;
            batch_valid_q <= '0;
            wr_count_q    <= '0;
            outstanding_q <= '0;
            finish_q      <= 1'b0;
            wdog_q        <= '0;
            error_q       <= 1'b0;
            build_start_q <= 1'b0;
            bfs_start_q   <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            total_q       <= total_d;
            points_done_q <= points_done_d;
            batch_valid_q <= batch_valid_d;
            wr_count_q    <= wr_count_d;
            outstanding_q <= outstanding_d;
            finish_q      <= finish_d;
            wdog_q        <= wdog_d;
            error_q       <= error_d;
            build_start_q <= build_start_d;
            bfs_start_q   <= bfs_start_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    assign o_state       = state_q;
    assign o_build_start = build_start_q;
    assign o_bfs_start   = bfs_start_q;
    assign o_batch_valid = batch_valid_q;
    assign o_points_done = points_done_q;
    assign o_wr_count    = wr_count_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_error       = error_q;

endmodule

// File: tb/tb_octree_bfs_ctrl.sv
// Directed self-checking bench for octree_bfs_ctrl; watchdog shortened to 16 cycles.
module tb_octree_bfs_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [31:0] i_total_points = '0;
    logic        i_read_TxnDone = 1'b0;
    logic        i_write_TxnDone = 1'b0;
    logic        i_initwritetxn = 1'b0;
    logic        i_work_done = 1'b0;
    logic        i_bfs_finish = 1'b0;
    logic [2:0]  o_state;
    logic        o_build_start;
    logic        o_bfs_start;
    logic [5:0]  o_batch_valid;
    logic [31:0] o_points_done;
    logic [15:0] o_wr_count;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    int tests_run = 0;
    int tests_failed = 0;
    int n_build = 0;
    int n_bfs = 0;
    int n_done = 0;
    int snap_build, snap_bfs, snap_done;

    octree_bfs_ctrl #(
        .POINTS_PER_BATCH(32),
        .WDOG_CYCLES     (16),
        .WCNT_WIDTH      (16)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_total_points (i_total_points),
        .i_read_TxnDone (i_read_TxnDone),
        .i_write_TxnDone(i_write_TxnDone),
        .i_initwritetxn (i_initwritetxn),
        .i_work_done    (i_work_done),
        .i_bfs_finish   (i_bfs_finish),
        .o_state        (o_state),
        .o_build_start  (o_build_start),
        .o_bfs_start    (o_bfs_start),
        .o_batch_valid  (o_batch_valid),
        .o_points_done  (o_points_done),
        .o_wr_count     (o_wr_count),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_error        (o_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and tally the pulses seen in that cycle.
    task automatic tick();
        @(negedge i_clk);
        if (o_build_start === 1'b1) n_build++;
        if (o_bfs_start === 1'b1) n_bfs++;
        if (o_done === 1'b1) n_done++;
    endtask

    task automatic start_run(input int total);
        i_total_points = total;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic run_batch(input int bv, input int pd_after, input bit last);
        check_eq("rd_state", 32'(o_state), 1);
        tick();
        tick();
        i_read_TxnDone = 1'b1;
        tick();
        i_read_TxnDone = 1'b0;
        check_eq("upd_state", 32'(o_state), 2);
        check_eq("batch_valid", 32'(o_batch_valid), bv);
        tick();
        check_eq("work_state", 32'(o_state), 3);
        check_eq("build_start", 32'(o_build_start), 1);
        check_eq("points_done", o_points_done, pd_after);
        for (int i = 0; i < 4; i++) tick();
        i_work_done = 1'b1;
        tick();
        i_work_done = 1'b0;
        check_eq("after_work", 32'(o_state), last ? 4 : 1);
        if (last) check_eq("bfs_start", 32'(o_bfs_start), 1);
    endtask

    task automatic pulse_init();
        i_initwritetxn = 1'b1;
        tick();
        i_initwritetxn = 1'b0;
    endtask

    task automatic pulse_wdone();
        i_write_TxnDone = 1'b1;
        tick();
        i_write_TxnDone = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check_eq("rst_state", 32'(o_state), 0);
        check_eq("rst_busy", 32'(o_busy), 0);
        check_eq("rst_error", 32'(o_error), 0);
        check_eq("rst_batch", 32'(o_batch_valid), 0);
        check_eq("rst_points", o_points_done, 0);
        check_eq("rst_wrcnt", 32'(o_wr_count), 0);
        i_rst = 1'b1;
        tick();

        // Total 96: three full batches, then the write phase.
        snap_build = n_build;
        snap_bfs = n_bfs;
        snap_done = n_done;
        start_run(96);
        check_eq("busy_run", 32'(o_busy), 1);
        run_batch(32, 32, 0);
        run_batch(32, 64, 0);
        run_batch(32, 96, 1);
        check_eq("build_cnt96", 32'(n_build - snap_build), 3);
        check_eq("bfs_cnt96", 32'(n_bfs - snap_bfs), 1);
        for (int i = 0; i < 4; i++) begin
            pulse_init();
            if (i == 3) begin
                i_bfs_finish = 1'b1;
                tick();
                i_bfs_finish = 1'b0;
                check_eq("fin_pending", 32'(o_state), 4);
            end
            pulse_wdone();
        end
        check_eq("wr_after4", 32'(o_state), 4);
        check_eq("wr_count4", 32'(o_wr_count), 4);
        tick();
        check_eq("done_state", 32'(o_state), 5);
        check_eq("done_pulse", 32'(o_done), 1);
        tick();
        check_eq("post_done", 32'(o_state), 0);
        check_eq("post_busy", 32'(o_busy), 0);
        check_eq("done_cnt", 32'(n_done - snap_done), 1);
        check_eq("held_points", o_points_done, 96);

        // Total 70: partial last batch of 6.
        snap_build = n_build;
        start_run(70);
        check_eq("start_clr_pts", o_points_done, 0);
        run_batch(32, 32, 0);
        run_batch(32, 64, 0);
        run_batch(6, 70, 1);
        check_eq("build_cnt70", 32'(n_build - snap_build), 3);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check_eq("abort_wr", 32'(o_state), 0);

        // Simultaneous init and completion with one write outstanding.
        start_run(5);
        run_batch(5, 5, 1);
        pulse_init();
        i_bfs_finish = 1'b1;
        tick();
        i_bfs_finish = 1'b0;
        i_initwritetxn = 1'b1;
        i_write_TxnDone = 1'b1;
        tick();
        i_initwritetxn = 1'b0;
        i_write_TxnDone = 1'b0;
        check_eq("simul_state", 32'(o_state), 4);
        tick();
        check_eq("simul_hold", 32'(o_state), 4);
        check_eq("simul_wrcnt", 32'(o_wr_count), 1);
        pulse_wdone();
        check_eq("simul_last", 32'(o_state), 4);
        tick();
        check_eq("simul_done", 32'(o_state), 5);
        tick();

        // Watchdog: no read completion for 16 cycles.
        snap_done = n_done;
        start_run(40);
        for (int i = 0; i < 15; i++) tick();
        check_eq("wdog_pre", 32'(o_state), 1);
        check_eq("wdog_pre_err", 32'(o_error), 0);
        tick();
        check_eq("wdog_state", 32'(o_state), 0);
        check_eq("wdog_err", 32'(o_error), 1);
        check_eq("wdog_nodone", 32'(n_done - snap_done), 0);
        start_run(0);
        check_eq("zero_state", 32'(o_state), 0);
        check_eq("zero_busy", 32'(o_busy), 0);
        check_eq("zero_err", 32'(o_error), 1);
        start_run(32);
        check_eq("restart_err", 32'(o_error), 0);
        check_eq("restart_st", 32'(o_state), 1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;

        // Abort in WORK.
        snap_done = n_done;
        start_run(10);
        tick();
        i_read_TxnDone = 1'b1;
        tick();
        i_read_TxnDone = 1'b0;
        tick();
        check_eq("abw_work", 32'(o_state), 3);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check_eq("abw_idle", 32'(o_state), 0);
        check_eq("abw_points", o_points_done, 10);
        tick();
        tick();
        check_eq("abw_nodone", 32'(n_done - snap_done), 0);

        // Reset in the middle of WRITING.
        start_run(5);
        run_batch(5, 5, 1);
        pulse_init();
        pulse_wdone();
        check_eq("mid_wrcnt", 32'(o_wr_count), 1);
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        check_eq("mrst_wrcnt", 32'(o_wr_count), 0);
        check_eq("mrst_state", 32'(o_state), 0);
        check_eq("mrst_points", o_points_done, 0);
        pulse_wdone();
        check_eq("mrst_ignore", 32'(o_wr_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
